// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter that shares one single-port on-chip RAM between two Avalon-MM masters.
// Read data comes back one cycle after the accept and is steered to the requester that issued the read.
module onchip_mem_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] rq0_address,
    input  logic [BE_W-1:0]   rq0_byteenable,
    input  logic              rq0_read,
    input  logic              rq0_write,
    input  logic [DATA_W-1:0] rq0_writedata,
    output logic              rq0_waitrequest,
    output logic [DATA_W-1:0] rq0_readdata,
    output logic              rq0_readdatavalid,

    input  logic [ADDR_W-1:0] rq1_address,
    input  logic [BE_W-1:0]   rq1_byteenable,
    input  logic              rq1_read,
    input  logic              rq1_write,
    input  logic [DATA_W-1:0] rq1_writedata,
    output logic              rq1_waitrequest,
    output logic [DATA_W-1:0] rq1_readdata,
    output logic              rq1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,

    output logic [CNT_W-1:0]  conflict_count
);

    logic ready;
    logic prio;
    logic rvalid;
    logic rtag;

    logic req0;
    logic req1;
    logic contend;
    logic grant0;
    logic grant1;
    logic sel;
    logic sel_write;
    logic read_accept;

    // When both request, prio names the winner; the mux follows requester 1 only when it is granted.
    always_comb begin
        req0        = rq0_read | rq0_write;
        req1        = rq1_read | rq1_write;
        contend     = req0 & req1;
        grant0      = ready & req0 & (~req1 | ~prio);
        grant1      = ready & req1 & (~req0 | prio);
        sel         = grant1;
        sel_write   = sel ? rq1_write : rq0_write;

        mem_address    = sel ? rq1_address   : rq0_address;
        mem_writedata  = sel ? rq1_writedata : rq0_writedata;
        mem_byteenable = sel_write ? (sel ? rq1_byteenable : rq0_byteenable) : {BE_W{1'b1}};
        mem_chipselect = grant0 | grant1;
        mem_write      = mem_chipselect & sel_write;
        mem_clken      = ready;
        read_accept    = mem_chipselect & ~sel_write;

        rq0_waitrequest = ~grant0;
        rq1_waitrequest = ~grant1;
        rq0_readdata    = mem_readdata;
        rq1_readdata    = mem_readdata;
    end

    // Gating with reset_n drops a response whose data phase overlaps an asserted reset.
    assign rq0_readdatavalid = reset_n & rvalid & ~rtag;
    assign rq1_readdatavalid = reset_n & rvalid & rtag;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ready          <= 1'b0;
            prio           <= 1'b0;
            rvalid         <= 1'b0;
            rtag           <= 1'b0;
            conflict_count <= '0;
        end else begin
            ready  <= 1'b1;
            rvalid <= read_accept;
            if (read_accept) begin
                rtag <= sel;
            end
            // A contended grant hands priority to the loser; requester 1 loses exactly when 0 wins.
            if (contend && ready) begin
                prio <= grant0;
                if (conflict_count != {CNT_W{1'b1}}) begin
                    conflict_count <= conflict_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural RAM; read responses are checked by a
// scoreboard monitor against queued expectations, grant and counter state are checked inline.
module tb_onchip_mem_arbiter;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [ADDR_W-1:0] rq0_address,    rq1_address;
    logic [BE_W-1:0]   rq0_byteenable, rq1_byteenable;
    logic              rq0_read,       rq1_read;
    logic              rq0_write,      rq1_write;
    logic [DATA_W-1:0] rq0_writedata,  rq1_writedata;
    logic              rq0_waitrequest,   rq1_waitrequest;
    logic [DATA_W-1:0] rq0_readdata,      rq1_readdata;
    logic              rq0_readdatavalid, rq1_readdatavalid;
    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] ram_rdata;
    logic [15:0]       conflict_count;

    logic              s_wait0, s_wait1, s_rdv0, s_rdv1;
    logic [DATA_W-1:0] s_rdata0, s_rdata1, s_mem_writedata;
    logic [ADDR_W-1:0] s_mem_address;
    logic [BE_W-1:0]   s_mem_byteenable;
    logic              s_mem_chipselect, s_mem_write, s_mem_clken;
    logic [3:0]        s_conflict_count;

    onchip_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .rq0_address(rq0_address), .rq0_byteenable(rq0_byteenable), .rq0_read(rq0_read),
        .rq0_write(rq0_write), .rq0_writedata(rq0_writedata), .rq0_waitrequest(rq0_waitrequest),
        .rq0_readdata(rq0_readdata), .rq0_readdatavalid(rq0_readdatavalid),
        .rq1_address(rq1_address), .rq1_byteenable(rq1_byteenable), .rq1_read(rq1_read),
        .rq1_write(rq1_write), .rq1_writedata(rq1_writedata), .rq1_waitrequest(rq1_waitrequest),
        .rq1_readdata(rq1_readdata), .rq1_readdatavalid(rq1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(ram_rdata), .conflict_count(conflict_count)
    );

    // Second instance with a 4-bit counter shares the stimulus to exercise saturation.
    onchip_mem_arbiter #(.CNT_W(4)) dut_small (
        .clk(clk), .reset_n(reset_n),
        .rq0_address(rq0_address), .rq0_byteenable(rq0_byteenable), .rq0_read(rq0_read),
        .rq0_write(rq0_write), .rq0_writedata(rq0_writedata), .rq0_waitrequest(s_wait0),
        .rq0_readdata(s_rdata0), .rq0_readdatavalid(s_rdv0),
        .rq1_address(rq1_address), .rq1_byteenable(rq1_byteenable), .rq1_read(rq1_read),
        .rq1_write(rq1_write), .rq1_writedata(rq1_writedata), .rq1_waitrequest(s_wait1),
        .rq1_readdata(s_rdata1), .rq1_readdatavalid(s_rdv1),
        .mem_address(s_mem_address), .mem_byteenable(s_mem_byteenable),
        .mem_chipselect(s_mem_chipselect), .mem_write(s_mem_write),
        .mem_writedata(s_mem_writedata), .mem_clken(s_mem_clken),
        .mem_readdata(ram_rdata), .conflict_count(s_conflict_count)
    );

    // RAM model: word i powers up as 0xC0DE0000 | i; one-cycle read latency, byte-lane writes.
    logic [DATA_W-1:0] ram [8192];
    initial begin
        for (int i = 0; i < 8192; i++) ram[i] = 32'hC0DE0000 | 32'(i);
        ram_rdata = '0;
        forever begin
            @(posedge clk);
            if (mem_clken && mem_chipselect) begin
                if (mem_write) begin
                    for (int b = 0; b < BE_W; b++)
                        if (mem_byteenable[b]) ram[mem_address][8*b +: 8] = mem_writedata[8*b +: 8];
                end else begin
                    ram_rdata <= ram[mem_address];
                end
            end
        end
    end

    logic [DATA_W-1:0] exp_q0[$];
    logic [DATA_W-1:0] exp_q1[$];
    int check_count = 0;
    int pass_count  = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
    endtask

    task automatic applyStimulus(input int rq, input logic rd, input logic wr,
                                 input logic [ADDR_W-1:0] addr, input logic [BE_W-1:0] be,
                                 input logic [DATA_W-1:0] data);
        if (rq == 0) begin
            rq0_read = rd; rq0_write = wr; rq0_address = addr; rq0_byteenable = be; rq0_writedata = data;
        end else begin
            rq1_read = rd; rq1_write = wr; rq1_address = addr; rq1_byteenable = be; rq1_writedata = data;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every readdatavalid must match the oldest expectation for that requester.
    always @(negedge clk) begin
        if (rq0_readdatavalid) begin
            if (exp_q0.size() == 0) begin
                check_count++;
                $display("[TB] FAIL rq0_unexpected_valid: got data 0x%08h, required no response", rq0_readdata);
            end else checkOutput("rq0_readdata", rq0_readdata, exp_q0.pop_front());
        end
        if (rq1_readdatavalid) begin
            if (exp_q1.size() == 0) begin
                check_count++;
                $display("[TB] FAIL rq1_unexpected_valid: got data 0x%08h, required no response", rq1_readdata);
            end else checkOutput("rq1_readdata", rq1_readdata, exp_q1.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at 100000, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 13'h0005, 4'hF, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 13'h0000, 4'h0, 32'h0);

        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("reset_wait0", 32'(rq0_waitrequest), 32'd1);
        end
        checkOutput("reset_wait1", 32'(rq1_waitrequest), 32'd1);
        checkOutput("reset_chipselect", 32'(mem_chipselect), 32'd0);
        checkOutput("reset_write", 32'(mem_write), 32'd0);
        checkOutput("reset_clken", 32'(mem_clken), 32'd0);
        checkOutput("reset_rdv", 32'({rq1_readdatavalid, rq0_readdatavalid}), 32'd0);
        checkOutput("reset_conflict", 32'(conflict_count), 32'd0);

        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("release_wait0", 32'(rq0_waitrequest), 32'd1);
        checkOutput("release_clken", 32'(mem_clken), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("first_grant_wait0", 32'(rq0_waitrequest), 32'd0);
        checkOutput("first_grant_cs", 32'(mem_chipselect), 32'd1);
        checkOutput("first_grant_clken", 32'(mem_clken), 32'd1);
        exp_q0.push_back(32'hC0DE0005);
        tick();

        applyStimulus(0, 1'b0, 1'b1, 13'h0010, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("lone_write_wait0", 32'(rq0_waitrequest), 32'd0);
        checkOutput("lone_mem_write", 32'(mem_write), 32'd1);
        tick();
        applyStimulus(0, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0);
        @(negedge clk);
        checkOutput("lone_read_wait0", 32'(rq0_waitrequest), 32'd0);
        exp_q0.push_back(32'hDEADBEEF);
        tick();

        applyStimulus(0, 1'b0, 1'b1, 13'h0020, 4'hF, 32'h11223344);
        @(negedge clk);
        checkOutput("lane_write1_wait0", 32'(rq0_waitrequest), 32'd0);
        tick();
        applyStimulus(0, 1'b0, 1'b1, 13'h0020, 4'h2, 32'hAABBCCDD);
        @(negedge clk);
        checkOutput("lane_write2_be", 32'(mem_byteenable), 32'h2);
        tick();
        applyStimulus(0, 1'b1, 1'b0, 13'h0020, 4'h2, 32'h0);
        @(negedge clk);
        checkOutput("lane_read_be", 32'(mem_byteenable), 32'hF);
        checkOutput("lane_read_wait0", 32'(rq0_waitrequest), 32'd0);
        exp_q0.push_back(32'h1122CC44);
        tick();

        // Contention: winners alternate starting from requester 0.
        applyStimulus(0, 1'b1, 1'b0, 13'h0100, 4'hF, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 13'h0200, 4'hF, 32'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("cont_wait0", 32'(rq0_waitrequest), 32'(k % 2));
            checkOutput("cont_wait1", 32'(rq1_waitrequest), 32'((k + 1) % 2));
            if (k % 2 == 0) exp_q0.push_back(32'hC0DE0100);
            else            exp_q1.push_back(32'hC0DE0200);
            tick();
        end
        applyStimulus(0, 1'b0, 1'b0, 13'h0000, 4'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 13'h0000, 4'h0, 32'h0);
        @(negedge clk);
        checkOutput("cont_conflict", 32'(conflict_count), 32'd8);
        checkOutput("cont_conflict_small", 32'(s_conflict_count), 32'd8);
        tick();

        applyStimulus(0, 1'b1, 1'b0, 13'h0100, 4'hF, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 13'h0200, 4'hF, 32'h0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checkOutput("sat_wait0", 32'(rq0_waitrequest), 32'(k % 2));
            if (k % 2 == 0) exp_q0.push_back(32'hC0DE0100);
            else            exp_q1.push_back(32'hC0DE0200);
            tick();
        end
        applyStimulus(0, 1'b0, 1'b0, 13'h0000, 4'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 13'h0000, 4'h0, 32'h0);
        @(negedge clk);
        checkOutput("sat_conflict_small", 32'(s_conflict_count), 32'd15);
        checkOutput("sat_conflict", 32'(conflict_count), 32'd28);
        tick();

        // One more contended grant to rq0 leaves prio pointing at rq1 before the reset test.
        applyStimulus(0, 1'b1, 1'b0, 13'h0100, 4'hF, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 13'h0200, 4'hF, 32'h0);
        @(negedge clk);
        checkOutput("pre_reset_wait0", 32'(rq0_waitrequest), 32'd0);
        checkOutput("pre_reset_wait1", 32'(rq1_waitrequest), 32'd1);
        exp_q0.push_back(32'hC0DE0100);
        tick();

        applyStimulus(0, 1'b0, 1'b0, 13'h0000, 4'h0, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 13'h0300, 4'hF, 32'h0);
        @(negedge clk);
        checkOutput("midreset_accept_wait1", 32'(rq1_waitrequest), 32'd0);
        tick();
        reset_n = 1'b0;
        applyStimulus(1, 1'b0, 1'b0, 13'h0000, 4'h0, 32'h0);
        @(negedge clk);
        checkOutput("midreset_rdv1", 32'(rq1_readdatavalid), 32'd0);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("midreset_conflict", 32'(conflict_count), 32'd0);
        checkOutput("midreset_conflict_small", 32'(s_conflict_count), 32'd0);
        checkOutput("midreset_rdv1_after", 32'(rq1_readdatavalid), 32'd0);
        checkOutput("midreset_wait", 32'({rq1_waitrequest, rq0_waitrequest}), 32'd3);
        tick();

        applyStimulus(0, 1'b1, 1'b0, 13'h0100, 4'hF, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 13'h0200, 4'hF, 32'h0);
        @(negedge clk);
        checkOutput("prio_reset_wait0", 32'(rq0_waitrequest), 32'd0);
        checkOutput("prio_reset_wait1", 32'(rq1_waitrequest), 32'd1);
        exp_q0.push_back(32'hC0DE0100);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 13'h0000, 4'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 13'h0000, 4'h0, 32'h0);
        tick();
        tick();
        @(negedge clk);
        checkOutput("q0_drained", 32'(exp_q0.size()), 32'd0);
        checkOutput("q1_drained", 32'(exp_q1.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

- Two-requester arbiter that shares the single-port on-chip RAM (8192 x 32, byte-enabled, one-cycle read latency) between two Avalon-MM masters, e.g. the processor data master and a circle-module DMA.
- Sits between the requesters and the RAM's s1 slave port; drives address, byteenable, chipselect, write, writedata and clken.
- Grants one access per cycle with round-robin fairness, back-pressures the loser with waitrequest, and returns read data with a one-cycle readdatavalid.

## Interface
Parameters:
- ADDR_W, 13, word-address width of the RAM
- DATA_W, 32, data width
- BE_W, 4, byteenable width (DATA_W/8)
- CNT_W, 16, width of the saturating conflict counter

Ports:
- clk  in  1  system clock; the only clock
- reset_n  in  1  synchronous, active-low reset
- rq0_address / rq1_address  in  ADDR_W  requester word address
- rq0_byteenable / rq1_byteenable  in  BE_W  write byte lanes
- rq0_read / rq1_read  in  1  read request, held until accepted
- rq0_write / rq1_write  in  1  write request, held until accepted
- rq0_writedata / rq1_writedata  in  DATA_W  write data
- rq0_waitrequest / rq1_waitrequest  out  1  request not accepted this cycle
- rq0_readdata / rq1_readdata  out  DATA_W  read data
- rq0_readdatavalid / rq1_readdatavalid  out  1  read data valid
- mem_address  out  ADDR_W  to RAM
- mem_byteenable  out  BE_W  to RAM
- mem_chipselect  out  1  to RAM
- mem_write  out  1  to RAM
- mem_writedata  out  DATA_W  to RAM
- mem_clken  out  1  RAM clock enable
- mem_readdata  in  DATA_W  from RAM, valid the cycle after a read is issued
- conflict_count  out  CNT_W  cycles in which both requesters contended

## Operation
- A requester i is requesting when rqi_read | rqi_write. If both read and write are high, the access is treated as a write (protocol error, not flagged).
- Grant is combinational each cycle:
  - only one requester requesting: that requester wins;
  - both requesting: the one selected by priority pointer `prio` wins.
- Pointer update on a contended grant: prio <= the loser. Uncontended grants leave prio unchanged.
- `ready` register: 0 in reset; set to 1 on the first clk edge with reset_n high. While ready=0, no grant is made and both waitrequests are 1.
- Winner, when ready=1:
  - rqi_waitrequest=0;
  - mem_chipselect=1;
  - mem_address, mem_byteenable, mem_writedata and mem_write come from the winner;
  - a read drives mem_byteenable = all ones.
- Loser (or any idle requester): waitrequest=1. An idle requester's waitrequest value is don't-care, but is driven as 1.
- No grant: mem_chipselect=0, mem_write=0; other mem outputs hold the requester-0 mux value.
- Read response pipeline, registered on an accepted read:
  - rvalid <= 1;
  - rtag <= winner index.
- Next cycle: rq[rtag]_readdatavalid = rvalid. Both readdata outputs are driven with mem_readdata unconditionally.
- Reads are fully pipelined: a new read may be accepted in the same cycle a prior read's data is returned.
- mem_clken = ready. The RAM is frozen until the first cycle after reset release.
- conflict_count: +1 on every cycle with both requesting and ready=1; saturates at 2^CNT_W-1.

## Timing
- Reset values (cycle after a reset_n=0 edge):
  - ready=0, prio=0, rvalid=0, rtag=0, conflict_count=0;
  - both waitrequests=1, both readdatavalids=0;
  - mem_chipselect=0, mem_write=0, mem_clken=0.
- Accept-to-memory latency is 0: the access is presented to the RAM in the accept cycle.
- Read latency is exactly 1: readdatavalid is high on the cycle after the accepting edge, for exactly one cycle per accepted read.
- Throughput: one access per cycle in total. A lone requester gets 100% of cycles. Two contending requesters alternate every cycle.
- Write followed by read to the same address, on consecutive cycles: the read returns the new data (write lands at the accept edge).
- Reset mid-read: an outstanding response is discarded; no readdatavalid appears after reset_n falls.
- reset_n low for a single cycle is sufficient.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with rq0_read=1, then release.
  - Required: waitrequest=1 during reset and the first cycle after release; grant in the 2nd cycle after release.
  - Required: readdatavalid one cycle later, with data = RAM init contents.
- Lone writer then reader: rq0 writes 0xDEADBEEF to address 0x0010 with byteenable=0xF, then reads 0x0010.
  - Required: zero wait states; rq0_readdata=0xDEADBEEF with rq0_readdatavalid the cycle after the read accept.
- Byte lanes: write 0x11223344 to 0x0020, then write 0xAABBCCDD with byteenable=0x2, then read.
  - Required: 0x1122CC44.
- Contention: both requesters read continuously for 8 cycles starting with prio=0.
  - Required: grants alternate rq0, rq1, rq0...; each gets 4 readdatavalids tagged correctly; conflict_count=8.
- Saturation: with CNT_W=4, contend for 20 cycles.
  - Required: conflict_count stops at 15.
- Reset mid-operation: rq1 read accepted at cycle N, reset_n=0 sampled at edge N+1.
  - Required: rq1_readdatavalid stays 0, and conflict_count and prio return to 0.
